// File: rtl/lcd_pkg.sv
// Shared types, constants and helpers for the HD44780 4-bit writer.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_INIT,
    ST_IDLE,
    ST_NIB_HI,
    ST_NIB_LO,
    ST_WAIT
  } lcd_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_EHI,
    PH_HOLD
  } lcd_phase_e;

  // Command latched at accept time.
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_cmd_t;

  localparam logic [3:0] LCD_INIT_NIB_8BIT = 4'h3;
  localparam logic [3:0] LCD_INIT_NIB_4BIT = 4'h2;
  localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME      = 8'h02;

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  function automatic logic lcd_is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
  endfunction

  function automatic int unsigned lcd_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Drives one nibble onto the LCD bus: setup, enable-high, hold.
// Phase timing runs on the top-level shared down-counter via cnt_load/cnt_zero.
module lcd_nibble_tx #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned E_HIGH_CYC = 12,
  parameter int unsigned HOLD_CYC   = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             rs,
  input  logic [3:0]       nibble,
  input  logic             cnt_zero,
  output logic             done,
  output logic             cnt_load,
  output logic [CNT_W-1:0] cnt_load_val,
  output logic             lcd_rs,
  output logic             lcd_e,
  output logic [3:0]       lcd_d
);
  import lcd_pkg::*;

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EHI_LOAD   = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);

  lcd_phase_e phase, phase_d;
  logic       rs_d;
  logic       e_d;
  logic [3:0] d_d;

  // Last hold cycle; kept out of the next-state block so start never loops back into it.
  assign done = (phase == PH_HOLD) && cnt_zero;

  // Phase register and registered pin outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase  <= PH_IDLE;
      lcd_rs <= 1'b0;
      lcd_e  <= 1'b0;
      lcd_d  <= 4'h0;
    end else begin
      phase  <= phase_d;
      lcd_rs <= rs_d;
      lcd_e  <= e_d;
      lcd_d  <= d_d;
    end
  end

  // Phase sequencing; bus values stay put until the next start.
  always_comb begin
    phase_d      = phase;
    rs_d         = lcd_rs;
    d_d          = lcd_d;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (phase)
      PH_SETUP: if (cnt_zero) begin
        phase_d      = PH_EHI;
        cnt_load     = 1'b1;
        cnt_load_val = EHI_LOAD;
      end
      PH_EHI: if (cnt_zero) begin
        phase_d      = PH_HOLD;
        cnt_load     = 1'b1;
        cnt_load_val = HOLD_LOAD;
      end
      PH_HOLD: if (done) phase_d = PH_IDLE;
      default: phase_d = phase;
    endcase
    // A start may coincide with the previous nibble's last hold cycle.
    if (start) begin
      phase_d      = PH_SETUP;
      rs_d         = rs;
      d_d          = nibble;
      cnt_load     = 1'b1;
      cnt_load_val = SETUP_LOAD;
    end
    e_d = (phase_d == PH_EHI);
  end

endmodule

// File: rtl/lcd_hd44780_writer.sv
// HD44780 4-bit byte writer: power-on init, valid/ready command port,
// high/low nibble ordering and per-command execution wait.
module lcd_hd44780_writer #(
  parameter int unsigned SETUP_CYC      = 2,
  parameter int unsigned E_HIGH_CYC     = 12,
  parameter int unsigned HOLD_CYC       = 4,
  parameter int unsigned SHORT_WAIT_CYC = 2500,
  parameter int unsigned LONG_WAIT_CYC  = 110000,
  parameter int unsigned POWERUP_CYC    = 750000,
  parameter int unsigned INIT_EN        = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [3:0] lcd_d
);
  import lcd_pkg::*;

  localparam int unsigned MAX_CYC = lcd_max(lcd_max(lcd_max(SETUP_CYC, E_HIGH_CYC),
                                                    lcd_max(HOLD_CYC, SHORT_WAIT_CYC)),
                                            lcd_max(LONG_WAIT_CYC, POWERUP_CYC));
  localparam int unsigned CNT_W = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PWR_LOAD   = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(LONG_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(SHORT_WAIT_CYC - 1);
  // The IDLE cycle holding the next accept is the last cycle of a byte's wait.
  localparam logic [CNT_W-1:0] LONG_BYTE_LOAD  = CNT_W'(LONG_WAIT_CYC - 2);
  localparam logic [CNT_W-1:0] SHORT_BYTE_LOAD = CNT_W'(SHORT_WAIT_CYC - 2);

  localparam lcd_state_e RESET_ST = (INIT_EN != 0) ? ST_POWERUP : ST_IDLE;

  lcd_state_e       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             cnt_zero;
  logic [1:0]       init_idx, init_idx_d;
  logic             init_done_d;
  lcd_cmd_t         cmd_q, cmd_q_d;
  logic             top_load;
  logic [CNT_W-1:0] top_load_val;

  logic             tx_start;
  logic             tx_rs;
  logic [3:0]       tx_nib;
  logic             tx_done;
  logic             tx_load;
  logic [CNT_W-1:0] tx_load_val;

  assign cnt_zero = (cnt == '0);

  lcd_nibble_tx #(
    .SETUP_CYC (SETUP_CYC),
    .E_HIGH_CYC(E_HIGH_CYC),
    .HOLD_CYC  (HOLD_CYC),
    .CNT_W     (CNT_W)
  ) u_tx (
    .clock       (clock),
    .reset       (reset),
    .start       (tx_start),
    .rs          (tx_rs),
    .nibble      (tx_nib),
    .cnt_zero    (cnt_zero),
    .done        (tx_done),
    .cnt_load    (tx_load),
    .cnt_load_val(tx_load_val),
    .lcd_rs      (lcd_rs),
    .lcd_e       (lcd_e),
    .lcd_d       (lcd_d)
  );

  // State, shared counter and registered handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RESET_ST;
      cnt       <= PWR_LOAD;
      init_idx  <= 2'd0;
      init_done <= 1'b0;
      cmd_ready <= 1'b0;
      cmd_q     <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      init_idx  <= init_idx_d;
      init_done <= init_done_d;
      cmd_ready <= (state_d == ST_IDLE) && init_done_d;
      cmd_q     <= cmd_q_d;
    end
  end

  // Shared down-counter: FSM loads win over nibble-phase loads, else count down to zero.
  always_comb begin
    cnt_d = cnt;
    if (top_load)      cnt_d = top_load_val;
    else if (tx_load)  cnt_d = tx_load_val;
    else if (!cnt_zero) cnt_d = cnt - CNT_W'(1);
  end

  // Top-level sequencing: power-up, init nibbles, command accept, nibble order, wait.
  always_comb begin
    state_d      = state;
    init_idx_d   = init_idx;
    init_done_d  = init_done;
    cmd_q_d      = cmd_q;
    top_load     = 1'b0;
    top_load_val = '0;
    tx_start     = 1'b0;
    tx_rs        = 1'b0;
    tx_nib       = 4'h0;
    case (state)
      ST_POWERUP: if (cnt_zero) begin
        state_d  = ST_INIT;
        tx_start = 1'b1;
        tx_nib   = LCD_INIT_NIB_8BIT;
      end
      ST_INIT: if (tx_done) begin
        state_d      = ST_WAIT;
        top_load     = 1'b1;
        top_load_val = (init_idx == 2'd3) ? SHORT_LOAD : LONG_LOAD;
      end
      ST_WAIT: if (cnt_zero) begin
        if (init_done) begin
          state_d = ST_IDLE;
        end else if (init_idx == 2'd3) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end else begin
          state_d    = ST_INIT;
          init_idx_d = init_idx + 2'd1;
          tx_start   = 1'b1;
          tx_nib     = (init_idx == 2'd2) ? LCD_INIT_NIB_4BIT : LCD_INIT_NIB_8BIT;
        end
      end
      ST_IDLE: begin
        if (!init_done) begin
          init_done_d = 1'b1;
        end else if (cmd_valid && cmd_ready) begin
          cmd_q_d.rs   = cmd_rs;
          cmd_q_d.data = cmd_data;
          state_d      = ST_NIB_HI;
          tx_start     = 1'b1;
          tx_rs        = cmd_rs;
          tx_nib       = cmd_data[7:4];
        end
      end
      ST_NIB_HI: if (tx_done) begin
        state_d  = ST_NIB_LO;
        tx_start = 1'b1;
        tx_rs    = cmd_q.rs;
        tx_nib   = cmd_q.data[3:0];
      end
      ST_NIB_LO: if (tx_done) begin
        if (lcd_is_long_cmd(cmd_q.rs, cmd_q.data)) begin
          if (LONG_WAIT_CYC > 1) begin
            state_d      = ST_WAIT;
            top_load     = 1'b1;
            top_load_val = LONG_BYTE_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (SHORT_WAIT_CYC > 1) begin
            state_d      = ST_WAIT;
            top_load     = 1'b1;
            top_load_val = SHORT_BYTE_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = RESET_ST;
    endcase
  end

endmodule
